wb_rr_arbiter: RTL

//  Two-master round-robin Wishbone B3 arbiter. Shares one slave-side bus
//  (the mapper/gpio/rom interconnect port) between two masters, e.g. the

---
 rtl/wb_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter with a registered grant held for a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a stalled-strobe watchdog that errors the owner and drops the bus.
module wb_rr_arbiter #(
    parameter int unsigned aw      = 32,
    parameter int unsigned dw      = 32,
    parameter int unsigned timeout = 255
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [2*aw-1:0]   wbm_adr_i,
    input  logic [2*dw-1:0]   wbm_dat_i,
    input  logic [2*dw/8-1:0] wbm_sel_i,
    input  logic [1:0]        wbm_we_i,
    input  logic [1:0]        wbm_cyc_i,
    input  logic [1:0]        wbm_stb_i,
    input  logic [5:0]        wbm_cti_i,
    input  logic [3:0]        wbm_bte_i,
    output logic [dw-1:0]     wbm_dat_o,
    output logic [1:0]        wbm_ack_o,
    output logic [1:0]        wbm_err_o,
    output logic [1:0]        wbm_rty_o,
    output logic [aw-1:0]     wbs_adr_o,
    output logic [dw-1:0]     wbs_dat_o,
    output logic [dw/8-1:0]   wbs_sel_o,
    output logic              wbs_we_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic [2:0]        wbs_cti_o,
    output logic [1:0]        wbs_bte_o,
    input  logic [dw-1:0]     wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i,
    input  logic              wbs_rty_i,
    output logic [1:0]        grant_o
);

    localparam int unsigned sw = dw / 8;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   owned, sel1;
    logic   stb_raw, cyc_raw, resp;
    logic   kill, to_err;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Release always passes through idle, giving one turnaround clock between owners.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (wbm_cyc_i[0] && (!wbm_cyc_i[1] || !ptr_q)) begin
                    state_d = StOwn0;
                end else if (wbm_cyc_i[1]) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!wbm_cyc_i[0]) begin
                    state_d = StIdle;
                    ptr_d   = 1'b1;
                end
            end
            StOwn1: begin
                if (!wbm_cyc_i[1]) begin
                    state_d = StIdle;
                    ptr_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign grant_o = {state_q == StOwn1, state_q == StOwn0};
    assign owned   = (state_q != StIdle);
    assign sel1    = (state_q == StOwn1);
    assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign cyc_raw = owned & (sel1 ? wbm_cyc_i[1] : wbm_cyc_i[0]);
    assign stb_raw = owned & (sel1 ? wbm_stb_i[1] : wbm_stb_i[0]);

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = 3'b000;
        wbs_bte_o = 2'b00;
        if (owned) begin
            wbs_adr_o = sel1 ? wbm_adr_i[aw +: aw] : wbm_adr_i[0 +: aw];
            wbs_dat_o = sel1 ? wbm_dat_i[dw +: dw] : wbm_dat_i[0 +: dw];
            wbs_sel_o = sel1 ? wbm_sel_i[sw +: sw] : wbm_sel_i[0 +: sw];
            wbs_we_o  = sel1 ? wbm_we_i[1] : wbm_we_i[0];
            wbs_cti_o = sel1 ? wbm_cti_i[5:3] : wbm_cti_i[2:0];
            wbs_bte_o = sel1 ? wbm_bte_i[3:2] : wbm_bte_i[1:0];
        end
    end

    assign wbs_cyc_o = cyc_raw & ~kill;
    assign wbs_stb_o = stb_raw & ~kill;
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = grant_o & {2{wbs_ack_i}};
    assign wbm_err_o = grant_o & {2{wbs_err_i | to_err}};
    assign wbm_rty_o = grant_o & {2{wbs_rty_i}};

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned cw = $clog2(timeout + 1);

    logic [cw-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          fire;

    // A slave response in the expiry clock suppresses the timeout.
    assign fire   = stb_raw && (cnt_q == cw'(timeout)) && !to_q && !resp;
    assign kill   = to_q | fire;
    assign to_err = fire;

    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (!owned) begin
            cnt_d = '0;
            to_d  = 1'b0;
        end else begin
            if (resp) begin
                cnt_d = '0;
            end else if (stb_raw && (cnt_q != cw'(timeout))) begin
                cnt_d = cnt_q + cw'(1);
            end
            if (fire) begin
                to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    assign kill   = 1'b0;
    assign to_err = 1'b0;
`endif

endmodule
